// File: rtl/vgaterm_bufarb.sv
// vgaterm_bufarb: display-RAM arbiter for a character terminal.
//   Video character fetches take strict priority on the RAM port. Host characters go
//   into a 4-entry FIFO and are drained one at a time in idle (vid_req=0) cycles.
//   Printable characters are written at the cursor; control codes only move the cursor.
//   A clear-screen fills all 80x30 cells with a space, then homes the cursor.
// Ports:
//   CLK_I, RST_I              clock, synchronous active-high reset
//   vid_req, vid_addr         video fetch request/address; vid_ack one cycle later
//   host_we, host_char        FIFO push; host_stall flags a full FIFO
//   cur_set, cur_row_in/col   cursor load (clamped to the screen)
//   clr_req, busy             start clear-screen; busy while clearing
//   cur_row, cur_col          current cursor position
//   ram_addr/wdata/we/re      registered display-RAM port
// Configuration:
//   VGATERM_AUTOWRAP_EN       defined: column overflow wraps to the next row;
//                             undefined: the column saturates at 79.
module vgaterm_bufarb (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        vid_req,
  input  logic [11:0] vid_addr,
  output logic        vid_ack,
  input  logic        host_we,
  input  logic [7:0]  host_char,
  output logic        host_stall,
  input  logic        cur_set,
  input  logic [4:0]  cur_row_in,
  input  logic [6:0]  cur_col_in,
  input  logic        clr_req,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        ram_re
);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  fifo_q [4];
  logic [7:0]  fifo_d [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [11:0] clr_addr_q, clr_addr_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        ram_we_q, ram_we_d, ram_re_q, ram_re_d, vid_ack_q, vid_ack_d;

  logic        push, pop, clr_done;
  logic [7:0]  head;
  logic [11:0] cur_addr;
  logic [4:0]  row_inc;

  assign head     = fifo_q[rd_ptr_q];
  assign cur_addr = 12'(row_q) * 12'd80 + 12'(col_q);
  assign row_inc  = (row_q == 5'd29) ? 5'd0 : row_q + 5'd1;
  // A full FIFO refuses the push even if a pop frees a slot in the same cycle.
  assign push     = host_we && (count_q != 3'd4);
  assign pop      = (state_q == IDLE) && (count_q != 3'd0) && !vid_req && !clr_req;

  always_comb begin
    state_d     = state_q;
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    row_d       = row_q;
    col_d       = col_q;
    clr_addr_d  = clr_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    vid_ack_d   = 1'b0;
    clr_done    = 1'b0;

    if (push) begin
      fifo_d[wr_ptr_q] = host_char;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;

    // Every cycle with vid_req high is its own read, even back-to-back.
    if (vid_req) begin
      ram_re_d   = 1'b1;
      vid_ack_d  = 1'b1;
      ram_addr_d = vid_addr;
    end

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = 12'd0;
        end else if (pop) begin
          state_d = WRITE;
          if (head >= 8'h20 && head <= 8'h7E) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = cur_addr;
            ram_wdata_d = head;
            if (col_q != 7'd79) begin
              col_d = col_q + 7'd1;
            end else begin
`ifdef VGATERM_AUTOWRAP_EN
              col_d = 7'd0;
              row_d = row_inc;
`endif
            end
          end else begin
            case (head)
              8'h0D:   col_d = 7'd0;
              8'h0A:   row_d = row_inc;
              8'h08:   if (col_q != 7'd0) col_d = col_q - 7'd1;
              default: ;
            endcase
          end
        end
      end
      WRITE: state_d = IDLE;
      CLEAR: begin
        if (!vid_req) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = clr_addr_q;
          ram_wdata_d = 8'h20;
          if (clr_addr_q == 12'd2399) begin
            state_d  = IDLE;
            clr_done = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + 12'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cur_set) begin
      row_d = (cur_row_in > 5'd29) ? 5'd29 : cur_row_in;
      col_d = (cur_col_in > 7'd79) ? 7'd79 : cur_col_in;
    end
    // Finishing a clear homes the cursor, even over a simultaneous load.
    if (clr_done) begin
      row_d = 5'd0;
      col_d = 7'd0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      row_q       <= 5'd0;
      col_q       <= 7'd0;
      clr_addr_q  <= 12'd0;
      ram_addr_q  <= 12'd0;
      ram_wdata_q <= 8'd0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      vid_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      row_q       <= row_d;
      col_q       <= col_d;
      clr_addr_q  <= clr_addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      vid_ack_q   <= vid_ack_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge CLK_I) begin
    fifo_q <= fifo_d;
  end

  assign vid_ack    = vid_ack_q;
  assign host_stall = (count_q == 3'd4);
  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign busy       = (state_q == CLEAR);
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign ram_re     = ram_re_q;

endmodule

// File: tb/tb_vgaterm_bufarb.sv
// Testbench for vgaterm_bufarb: directed steps plus a randomized character stream,
// checked against a cursor/write-list model of the terminal behaviour.
// Honours VGATERM_AUTOWRAP_EN the same way the design does.
module tb_vgaterm_bufarb;

  logic        clk = 1'b0;
  logic        RST_I = 1'b0;
  logic        vid_req = 1'b0;
  logic [11:0] vid_addr = 12'd0;
  logic        host_we = 1'b0;
  logic [7:0]  host_char = 8'd0;
  logic        cur_set = 1'b0;
  logic [4:0]  cur_row_in = 5'd0;
  logic [6:0]  cur_col_in = 7'd0;
  logic        clr_req = 1'b0;
  logic        vid_ack, host_stall, busy, ram_we, ram_re;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;

  vgaterm_bufarb dut (
    .CLK_I(clk), .RST_I(RST_I), .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .host_we(host_we), .host_char(host_char), .host_stall(host_stall),
    .cur_set(cur_set), .cur_row_in(cur_row_in), .cur_col_in(cur_col_in),
    .clr_req(clr_req), .cur_row(cur_row), .cur_col(cur_col), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int we_cnt = 0;
  bit chk_wr = 1'b1;
  int exp_wr[$];          // expected writes, (addr << 8) | data, in order
  int m_row = 0;
  int m_col = 0;
  logic [7:0] ctrls [7] = '{8'h0D, 8'h0A, 8'h08, 8'h00, 8'h1F, 8'h7F, 8'hFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Terminal behaviour in screen terms: what a character does to RAM and cursor.
  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_wr.push_back(((m_row * 80 + m_col) << 8) | int'(c));
      if (m_col < 79) m_col++;
      else begin
`ifdef VGATERM_AUTOWRAP_EN
        m_col = 0;
        m_row = (m_row + 1) % 30;
`endif
      end
    end else if (c == 8'h0D) m_col = 0;
    else if (c == 8'h0A) m_row = (m_row + 1) % 30;
    else if (c == 8'h08) begin
      if (m_col > 0) m_col--;
    end
  endtask

  task automatic tick();
    logic pv;
    logic [11:0] pa;
    int e;
    pv = vid_req;
    pa = vid_addr;
    @(posedge clk);
    #1;
    cyc++;
    chk("vid_ack", vid_ack, pv);
    chk("ram_re", ram_re, pv);
    if (pv) chk("vid_rd_addr", ram_addr, pa);
    chk("we_re_excl", ram_we & ram_re, 0);
    if (vid_ack) ack_cnt++;
    if (ram_we) begin
      we_cnt++;
      if (chk_wr) begin
        if (exp_wr.size() == 0) chk("extra_write", ram_we, 0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", ram_addr, e >> 8);
          chk("wr_data", ram_wdata, e & 255);
        end
      end
    end
  endtask

  task automatic push(input logic [7:0] c, input bit accept);
    host_we = 1'b1;
    host_char = c;
    if (accept) model_char(c);
    tick();
    host_we = 1'b0;
  endtask

  task automatic set_cursor(input logic [4:0] r, input logic [6:0] c);
    cur_set = 1'b1;
    cur_row_in = r;
    cur_col_in = c;
    m_row = (r > 29) ? 29 : int'(r);
    m_col = (c > 79) ? 79 : int'(c);
    tick();
    cur_set = 1'b0;
  endtask

  task automatic drain(input int n);
    vid_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_row"}, cur_row, m_row);
    chk({tag, "_col"}, cur_col, m_col);
  endtask

  initial begin
    int busy_bad;
    bit found;
    logic [7:0] c;

    // Reset state
    RST_I = 1'b1;
    repeat (2) tick();
    RST_I = 1'b0;
    chk("rst_vid_ack", vid_ack, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", host_stall, 0);
    chk_cursor("rst");

    // Five printables back to back, no video traffic
    we_cnt = 0;
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1'b1);
    drain(12);
    chk("seq_pending", exp_wr.size(), 0);
    chk("seq_writes", we_cnt, 5);
    chk_cursor("seq");

    // Ten cycles of video with two characters queued
    ack_cnt = 0;
    we_cnt = 0;
    vid_req = 1'b1;
    vid_addr = 12'($urandom_range(0, 2399));
    push(8'h41, 1'b1);
    vid_addr = 12'($urandom_range(0, 2399));
    push(8'h42, 1'b1);
    for (int i = 0; i < 8; i++) begin
      vid_addr = 12'($urandom_range(0, 2399));
      tick();
    end
    chk("vid_acks", ack_cnt, 10);
    chk("vid_no_we", we_cnt, 0);
    drain(8);
    chk("vid_after_pending", exp_wr.size(), 0);
    chk("vid_after_writes", we_cnt, 2);

    // Fill the FIFO under video traffic; the fifth push is dropped
    we_cnt = 0;
    vid_req = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h50 + i), 1'b1);
    chk("full_stall", host_stall, 1);
    push(8'h54, 1'b0);
    chk("full_stall_held", host_stall, 1);
    drain(12);
    chk("full_pending", exp_wr.size(), 0);
    chk("full_writes", we_cnt, 4);
    chk("full_stall_clear", host_stall, 0);
    chk_cursor("full");

    // Bottom-right corner overflow
    set_cursor(5'd29, 7'd79);
    chk_cursor("corner_set");
    push(8'h41, 1'b1);
    drain(6);
    chk("corner_pending", exp_wr.size(), 0);
    chk_cursor("corner");

    // Clamp out-of-range cursor loads
    set_cursor(5'd31, 7'd127);
    chk_cursor("clamp");
    set_cursor(5'd0, 7'd0);
    push(8'h08, 1'b1);
    drain(4);
    chk_cursor("bs_sat");

    // Random character stream; video idle on every other cycle keeps the FIFO draining
    set_cursor(5'd27, 7'd70);
    for (int i = 0; i < 300; i++) begin
      vid_req = (cyc % 2 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      vid_addr = 12'($urandom_range(0, 2399));
      if (i % 3 == 0) begin
        c = ($urandom_range(0, 3) == 0) ? ctrls[$urandom_range(0, 6)]
                                        : 8'($urandom_range(32, 126));
        push(c, 1'b1);
      end else tick();
    end
    drain(20);
    chk("rand_pending", exp_wr.size(), 0);
    chk_cursor("rand");

    // Clear-screen with toggling video, plus ignored clr_req, a cursor load and a push
    set_cursor(5'd5, 7'd5);
    for (int a = 0; a < 2400; a++) exp_wr.push_back((a << 8) | 32);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_bad = 0;
    for (int i = 0; i < 6000 && exp_wr.size() > 0; i++) begin
      vid_req = cyc[0];
      vid_addr = 12'($urandom_range(0, 2399));
      clr_req = (i == 300);
      cur_set = (i == 500);
      cur_row_in = 5'd3;
      cur_col_in = 7'd3;
      host_we = (i == 700);
      host_char = 8'h5A;
      tick();
      clr_req = 1'b0;
      host_we = 1'b0;
      if (i == 500) begin
        cur_set = 1'b0;
        m_row = 3;
        m_col = 3;
        chk_cursor("clr_curset");
      end
      cur_set = 1'b0;
      if (exp_wr.size() > 0 && busy !== 1'b1) busy_bad++;
    end
    chk("clr_pending", exp_wr.size(), 0);
    chk("clr_busy_held", busy_bad, 0);
    chk("clr_busy_done", busy, 0);
    m_row = 0;
    m_col = 0;
    chk_cursor("clr_end");
    model_char(8'h5A);
    drain(8);
    chk("clr_push_pending", exp_wr.size(), 0);
    chk_cursor("clr_push");

    // Reset in the middle of a clear
    chk_wr = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      if (ram_we && ram_addr == 12'd1000) found = 1'b1;
    end
    chk("abort_reached", found, 1);
    RST_I = 1'b1;
    tick();
    RST_I = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_we", ram_we, 0);
    m_row = 0;
    m_col = 0;
    exp_wr.delete();
    chk_wr = 1'b1;
    we_cnt = 0;
    repeat (6) tick();
    chk("abort_no_we", we_cnt, 0);
    push(8'h0D, 1'b1);
    push(8'h0A, 1'b1);
    push(8'h08, 1'b1);
    drain(10);
    chk("ctrl_no_we", we_cnt, 0);
    chk_cursor("ctrl");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
